// File: rtl/mem_arb_pkg.sv
// Shared types and the rotating-priority picker for mem_port_arbiter.
package mem_arb_pkg;

   typedef enum logic {ST_INIT, ST_RUN} arb_state_e;

   typedef enum logic [1:0] {
      REQ_WR = 2'd0,
      REQ_BW = 2'd1,
      REQ_RD = 2'd2
   } req_id_e;

   localparam int NUM_REQ = 3;

   // Rotate so ptr sits at bit 0, take lowest set bit, rotate back.
   function automatic logic [NUM_REQ-1:0] rr_pick(
      input logic [NUM_REQ-1:0] req,
      input logic [1:0]         ptr
   );
      logic [2*NUM_REQ-1:0] dbl;
      logic [NUM_REQ-1:0]   rot;
      logic [NUM_REQ-1:0]   pick;
      dbl  = {req, req};
      rot  = dbl[ptr +: NUM_REQ];
      pick = rot & (~rot + 1'b1);
      dbl  = {pick, pick} << ptr;
      return dbl[2*NUM_REQ-1 -: NUM_REQ];
   endfunction

endpackage

// File: rtl/mem_arb_array.sv
// Single-ported storage: masked write port, registered synchronous read port.
module mem_arb_array
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] wmask_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i)
                         | (wdata_i & wmask_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of word-write, bit-write and read onto one memory port.
// Define MEM_ARB_ASSERT_EN to compile in handshake/grant protocol checks.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   wr_valid,
   output logic                                   wr_ready,
   input  logic [ADDR_W-1:0]                      wr_addr,
   input  logic [DATA_W-1:0]                      wr_data,
   input  logic                                   bw_valid,
   output logic                                   bw_ready,
   input  logic [ADDR_W-1:0]                      bw_addr,
   input  logic [(DATA_W>1?$clog2(DATA_W):1)-1:0] bw_index,
   input  logic                                   bw_value,
   input  logic                                   rd_valid,
   output logic                                   rd_ready,
   input  logic [ADDR_W-1:0]                      rd_addr,
   output logic                                   rsp_valid,
   output logic [DATA_W-1:0]                      rsp_data,
   output logic                                   init_done
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   arb_state_e          state_q;
   logic [ADDR_W-1:0]   init_cnt_q;
   logic                init_done_q;
   logic [1:0]          rr_ptr_q;
   logic [1:0]          rr_ptr_d;
   logic                rsp_valid_q;
   logic [NUM_REQ-1:0]  req;
   logic [NUM_REQ-1:0]  gnt;
   logic [DATA_W-1:0]   bw_mask;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_wmask;

   assign req = {rd_valid, bw_valid, wr_valid};
   assign gnt = (state_q == ST_RUN) ? rr_pick(req, rr_ptr_q) : '0;

   assign wr_ready = gnt[REQ_WR];
   assign bw_ready = gnt[REQ_BW];
   assign rd_ready = gnt[REQ_RD];

   // Out-of-range indices produce an empty mask, so the write is a no-op.
   always_comb begin
      bw_mask = '0;
      for (int b = 0; b < DATA_W; b++) begin
         bw_mask[b] = (bw_index == IDX_W'(b));
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      mem_wmask = '1;
      unique case (1'b1)
         (state_q == ST_INIT): begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_q;
            mem_wdata = '0;
         end
         gnt[REQ_WR]: mem_we = 1'b1;
         gnt[REQ_BW]: begin
            mem_we    = 1'b1;
            mem_waddr = bw_addr;
            mem_wdata = {DATA_W{bw_value}};
            mem_wmask = bw_mask;
         end
         default: ;
      endcase
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      unique case (1'b1)
         gnt[REQ_WR]: rr_ptr_d = 2'd1;
         gnt[REQ_BW]: rr_ptr_d = 2'd2;
         gnt[REQ_RD]: rr_ptr_d = 2'd0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
         rr_ptr_q    <= 2'd0;
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= gnt[REQ_RD];
         rr_ptr_q    <= rr_ptr_d;
         unique case (state_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q + 1'b1;
               if (init_cnt_q == ADDR_W'(DEPTH-1)) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end
            end
            ST_RUN: ;
            default: state_q <= ST_INIT;
         endcase
      end
   end

   mem_arb_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .wmask_i (mem_wmask),
      .re_i    (gnt[REQ_RD]),
      .raddr_i (rd_addr),
      .rdata_o (rsp_data)
   );

   assign rsp_valid = rsp_valid_q;
   assign init_done = init_done_q;

`ifdef MEM_ARB_ASSERT_EN
   logic              wr_stall_q, bw_stall_q, rd_stall_q;
   logic [ADDR_W-1:0] wr_addr_q, bw_addr_q, rd_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [IDX_W-1:0]  bw_index_q;
   logic              bw_value_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_stall_q <= 1'b0;
         bw_stall_q <= 1'b0;
         rd_stall_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         bw_addr_q  <= '0;
         bw_index_q <= '0;
         bw_value_q <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         wr_stall_q <= wr_valid & ~wr_ready;
         bw_stall_q <= bw_valid & ~bw_ready;
         rd_stall_q <= rd_valid & ~rd_ready;
         wr_addr_q  <= wr_addr;
         wr_data_q  <= wr_data;
         bw_addr_q  <= bw_addr;
         bw_index_q <= bw_index;
         bw_value_q <= bw_value;
         rd_addr_q  <= rd_addr;
         assert ($onehot0(gnt))
            else $error("mem_port_arbiter: readies not one-hot");
         assert (init_done_q || gnt == '0)
            else $error("mem_port_arbiter: ready before init_done");
         if (wr_stall_q)
            assert (wr_valid && wr_addr == wr_addr_q
                    && wr_data == wr_data_q)
               else $error("mem_port_arbiter: wr request unstable");
         if (bw_stall_q)
            assert (bw_valid && bw_addr == bw_addr_q
                    && bw_index == bw_index_q
                    && bw_value == bw_value_q)
               else $error("mem_port_arbiter: bw request unstable");
         if (rd_stall_q)
            assert (rd_valid && rd_addr == rd_addr_q)
               else $error("mem_port_arbiter: rd request unstable");
      end
   end
`else
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_valid, wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              bw_valid, bw_ready;
   logic [ADDR_W-1:0] bw_addr;
   logic [2:0]        bw_index;
   logic              bw_value;
   logic              rd_valid, rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              init_done;

   int passed = 0;
   int total  = 0;

   mem_port_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .bw_valid  (bw_valid),
      .bw_ready  (bw_ready),
      .bw_addr   (bw_addr),
      .bw_index  (bw_index),
      .bw_value  (bw_value),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_addr   (rd_addr),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      #1;
      chk("wr_ready", wr_ready, 1);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic do_bw(input logic [ADDR_W-1:0] a, input logic [2:0] i,
                        input logic v);
      bw_valid = 1'b1;
      bw_addr  = a;
      bw_index = i;
      bw_value = v;
      #1;
      chk("bw_ready", bw_ready, 1);
      tick();
      bw_valid = 1'b0;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] exp);
      rd_valid = 1'b1;
      rd_addr  = a;
      #1;
      chk("rd_ready", rd_ready, 1);
      tick();
      rd_valid = 1'b0;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] rot_exp [6];
      rot_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rst_n = 1'b0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      bw_valid = 1'b0; bw_addr = '0; bw_index = '0; bw_value = 1'b0;
      rd_valid = 1'b0; rd_addr = '0;
      tick();
      tick();
      chk("rst_init_done", init_done, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);

      // read held pending across the clear; granted on init_done cycle
      rd_valid = 1'b1;
      rd_addr  = 4'd0;
      rst_n    = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("init_done_seq", init_done, (k == 16));
         chk("rd_ready_init", rd_ready, (k == 16));
         chk("wr_ready_init", wr_ready, 0);
      end
      tick();
      rd_valid = 1'b0;
      chk("first_rsp_valid", rsp_valid, 1);
      chk("first_rsp_data", rsp_data, 0);
      tick();
      chk("rsp_pulse_end", rsp_valid, 0);

      for (int a = 0; a < 16; a++) do_read(4'(a), 8'h00);

      do_write(4'd3, 8'hA5);
      do_read(4'd3, 8'hA5);
      tick();
      chk("rsp_one_cycle", rsp_valid, 0);
      do_bw(4'd3, 3'd1, 1'b1);
      do_read(4'd3, 8'hA7);
      do_bw(4'd3, 3'd7, 1'b0);
      do_read(4'd3, 8'h27);

      // all three contend starting from rr_ptr = 0
      wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'h11;
      bw_valid = 1'b1; bw_addr = 4'd6; bw_index = 3'd2; bw_value = 1'b1;
      rd_valid = 1'b1; rd_addr = 4'd3;
      #1;
      for (int c = 0; c < 6; c++) begin
         chk("rotate_ready", {rd_ready, bw_ready, wr_ready}, rot_exp[c]);
         tick();
         chk("rotate_rsp", rsp_valid, (c % 3 == 2));
         if (c % 3 == 2) chk("rotate_data", rsp_data, 8'h27);
      end
      rd_valid = 1'b0;
      #1;
      chk("wind_wr", {rd_ready, bw_ready, wr_ready}, 3'b001);
      tick();
      wr_valid = 1'b0;
      #1;
      chk("wind_bw", {rd_ready, bw_ready, wr_ready}, 3'b010);
      tick();
      bw_valid = 1'b0;
      do_read(4'd5, 8'h11);
      do_read(4'd6, 8'h04);
      do_read(4'd3, 8'h27);

      // reset while a response is in flight
      do_write(4'd3, 8'hA5);
      rd_valid = 1'b1;
      rd_addr  = 4'd3;
      #1;
      chk("abort_rd_ready", rd_ready, 1);
      tick();
      rd_valid = 1'b0;
      chk("abort_rsp_pre", rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_rsp_data", rsp_data, 0);
      chk("abort_init_done", init_done, 0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("reinit_rsp", rsp_valid, 0);
         chk("reinit_done", init_done, (k == 16));
      end
      do_read(4'd3, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported DEPTH x DATA_W storage array among three requesters: word writer, bit writer and reader. One array operation is performed per cycle, with round-robin fairness. After each reset the block clears the whole array before accepting traffic. It sits between datapath stages that would otherwise need multiple write ports on one memory.

## Interface
- ADDR_W, 4, address width
- DATA_W, 8, word width
- DEPTH, 2**ADDR_W, number of words (derived, not overridable)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid / wr_ready  in / out  1  word-write handshake
- wr_addr  in  ADDR_W  word-write address
- wr_data  in  DATA_W  word-write data
- bw_valid / bw_ready  in / out  1  bit-write handshake
- bw_addr  in  ADDR_W  bit-write address
- bw_index  in  $clog2(DATA_W)  bit position
- bw_value  in  1  bit value
- rd_valid / rd_ready  in / out  1  read-request handshake
- rd_addr  in  ADDR_W  read address
- rsp_valid  out  1  read response strobe
- rsp_data  out  DATA_W  read response data
- init_done  out  1  high once the post-reset clear has completed

## Operation
- FSM has two states:
  - ST_INIT: a counter walks addresses 0..DEPTH-1, writing 0 to one address per cycle. At count DEPTH-1 the FSM moves to ST_RUN.
  - ST_RUN: terminal state; it is left only by reset.
- In ST_INIT, all readies are 0 and init_done is 0.
- In ST_RUN, at most one ready is high per cycle (one-hot or zero).
  - The grant goes to the first requester with valid high, scanning in rotating order from rr_ptr.
  - Requester indices: 0 = word write, 1 = bit write, 2 = read.
- Readies are combinational from valids and rr_ptr. A transfer occurs when valid and ready are both high.
- After a transfer by requester i, rr_ptr becomes (i+1) mod 3. With no transfer, rr_ptr holds.
- Word write: mem[wr_addr] <= wr_data.
- Bit write: mem[bw_addr][bw_index] <= bw_value. The other bits are unchanged, with no read-modify-write bubble.
- Read: on the next edge, rsp_data <= mem[rd_addr] and rsp_valid is pulsed for 1 cycle. There is no rsp_ready; the consumer always accepts the response.
- Requesters must hold valid and their payload stable until ready is high.

## Timing
- On reset assertion, immediately:
  - state = ST_INIT, init counter = 0, rr_ptr = 0
  - rsp_valid = 0, rsp_data = 0, init_done = 0
- Reset asserted mid-operation aborts any pending response and restarts the clear sequence. An in-flight request is dropped and never receives a ready.
- The clear sequence uses edges 1..DEPTH after rst_n release. init_done rises after edge DEPTH; the first grant can happen in that same cycle.
- Read latency is 1 cycle from the handshake edge to rsp_valid.
- A write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the new data.
- bw_index values >= DATA_W (possible only when DATA_W is not a power of 2) are ignored: the handshake completes but the array is unchanged.
- Throughput: 1 operation per cycle. With all three valids held high, grants rotate strictly 0,1,2,0,...

## Configuration
- MEM_ARB_ASSERT_EN defined: immediate assertions inside the clocked process, each calling $error on failure, check that:
  - the readies are one-hot or zero;
  - no ready is high while init_done = 0;
  - a valid that was high with ready low does not drop and its payload does not change in the next cycle.
- Undefined: no checks are compiled in, and functional behaviour is identical.

## Structure
- Package mem_arb_pkg:
  - typedef enum arb_state_e {ST_INIT, ST_RUN}
  - typedef enum req_id_e {REQ_WR=0, REQ_BW=1, REQ_RD=2}
  - localparam NUM_REQ = 3
- Sub-module mem_arb_array holds the DEPTH x DATA_W storage. It has:
  - one write port with address, data, per-bit mask and enable;
  - one synchronous read port with address, enable and registered data.
- mem_port_arbiter owns the FSM, the init counter, rr_ptr, and the grant and mux logic. The init writes use the word port with mask all ones.

## Test plan
- Reset release, all valids low → init_done = 0 for 16 cycles, then 1. Reading each address 0..15 afterwards returns 0x00.
- Word write addr 3 = 0xA5, then read addr 3 → rsp_valid one cycle after the read handshake, rsp_data = 0xA5.
- After 0xA5 at addr 3, bit write addr 3, index 1, value 1, then read → 0xA7. Then bit write index 7, value 0, then read → 0x27.
- All three valids held high for 6 cycles starting with rr_ptr = 0 → ready sequence wr, bw, rd, wr, bw, rd, with exactly one ready per cycle.
- rst_n pulsed low while a read is in flight → rsp_valid = 0 immediately, no response after release. The array is re-cleared: the prior 0xA5 at addr 3 reads back 0x00.
- With MEM_ARB_ASSERT_EN defined: drop wr_valid while wr_ready is low → $error fires. With the macro undefined, the same stimulus gives no error.
